// File: rtl/pixel_frame_server.sv
// Frame-store responder: loads a source frame, serves pixel reads, captures
// processed pixels into a destination frame and streams that frame out.
module pixel_frame_server #(
  parameter int V_SIZE = 50,
  parameter int H_SIZE = 50,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_val,
  input  logic [23:0]       load_data,
  input  logic              rd_pixel,
  input  logic [ADDR_W-1:0] addr_pixel,
  output logic              pixel_val,
  output logic [23:0]       pixel_in,
  input  logic              wr_pixel,
  input  logic [23:0]       pixel_out,
  input  logic              proc_done,
  output logic              drain_val,
  input  logic              drain_rdy,
  output logic [23:0]       drain_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_addr,
  output logic              err_ovf
);

  localparam int N = V_SIZE * H_SIZE;
  localparam logic [ADDR_W:0] N_P   = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] ONE_P = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_P = (ADDR_W+1)'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SERVE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          r_state;
  logic [23:0]     r_src_mem [0:N-1];
  logic [23:0]     r_dst_mem [0:N-1];
  logic [ADDR_W:0] r_load_ptr;
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_drain_ptr;
  logic            r_pixel_val;
  logic [23:0]     r_pixel_in;
  logic            r_drain_val;
  logic [23:0]     r_drain_data;
  logic            r_busy;
  logic            r_frame_done;
  logic            r_err_addr;
  logic            r_err_ovf;

  logic            w_wr_en;
  logic [ADDR_W:0] w_wr_next;
  logic            w_exit;
  logic            w_addr_ok;
  logic            w_xfer;
  logic            w_pf_en;

  // In DRAIN r_wr_ptr is frozen and serves as the drain word count.
  always_comb begin
    w_wr_en   = (r_state == S_SERVE) && wr_pixel && (r_wr_ptr != N_P);
    w_wr_next = w_wr_en ? (r_wr_ptr + ONE_P) : r_wr_ptr;
    w_exit    = (w_wr_next == N_P) || proc_done;
    w_addr_ok = ({1'b0, addr_pixel} < N_P);
    w_xfer    = r_drain_val && drain_rdy;
    w_pf_en   = (!r_drain_val || drain_rdy) && (r_drain_ptr != r_wr_ptr);
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_LOAD) && load_val) begin
      r_src_mem[r_load_ptr[ADDR_W-1:0]] <= load_data;
    end
    if (w_wr_en) begin
      r_dst_mem[r_wr_ptr[ADDR_W-1:0]] <= pixel_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_load_ptr   <= ZERO_P;
      r_wr_ptr     <= ZERO_P;
      r_drain_ptr  <= ZERO_P;
      r_pixel_val  <= 1'b0;
      r_pixel_in   <= 24'h0;
      r_drain_val  <= 1'b0;
      r_drain_data <= 24'h0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_addr   <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_pixel_val  <= 1'b0;
      if ((r_state == S_SERVE) && rd_pixel) begin
        r_pixel_val <= 1'b1;
        r_pixel_in  <= w_addr_ok ? r_src_mem[addr_pixel] : 24'h0;
        if (!w_addr_ok) r_err_addr <= 1'b1;
      end
      if ((r_state != S_IDLE) && wr_pixel && (r_wr_ptr == N_P)) r_err_ovf <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_busy      <= 1'b1;
            r_load_ptr  <= ZERO_P;
            r_wr_ptr    <= ZERO_P;
            r_drain_ptr <= ZERO_P;
            r_err_addr  <= 1'b0;
            r_err_ovf   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_val) begin
            r_load_ptr <= r_load_ptr + ONE_P;
            if (r_load_ptr == (N_P - ONE_P)) r_state <= S_SERVE;
          end
        end
        S_SERVE: begin
          r_wr_ptr <= w_wr_next;
          if (w_exit) begin
            // An empty result frame has nothing to stream, so finish at once.
            if (w_wr_next == ZERO_P) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The output register doubles as the RAM read register, refilled whenever it frees up.
          if (w_pf_en) begin
            r_drain_data <= r_dst_mem[r_drain_ptr[ADDR_W-1:0]];
            r_drain_val  <= 1'b1;
            r_drain_ptr  <= r_drain_ptr + ONE_P;
          end else if (w_xfer) begin
            r_drain_val <= 1'b0;
            if (r_drain_ptr == r_wr_ptr) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_val  = r_pixel_val;
  assign pixel_in   = r_pixel_in;
  assign drain_val  = r_drain_val;
  assign drain_data = r_drain_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign err_addr   = r_err_addr;
  assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_pixel_frame_server.sv
// Randomized bench for pixel_frame_server against a frame-level reference model
// (source array, result queue, sticky error flags).
module tb_pixel_frame_server;

  localparam int N      = 2500;
  localparam int ADDR_W = 12;

  logic              clk;
  logic              reset;
  logic              start;
  logic              load_val;
  logic [23:0]       load_data;
  logic              rd_pixel;
  logic [ADDR_W-1:0] addr_pixel;
  logic              pixel_val;
  logic [23:0]       pixel_in;
  logic              wr_pixel;
  logic [23:0]       pixel_out;
  logic              proc_done;
  logic              drain_val;
  logic              drain_rdy;
  logic [23:0]       drain_data;
  logic              busy;
  logic              frame_done;
  logic              err_addr;
  logic              err_ovf;

  pixel_frame_server #(.V_SIZE(50), .H_SIZE(50), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val), .load_data(load_data),
    .rd_pixel(rd_pixel), .addr_pixel(addr_pixel), .pixel_val(pixel_val), .pixel_in(pixel_in),
    .wr_pixel(wr_pixel), .pixel_out(pixel_out), .proc_done(proc_done),
    .drain_val(drain_val), .drain_rdy(drain_rdy), .drain_data(drain_data),
    .busy(busy), .frame_done(frame_done), .err_addr(err_addr), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [23:0] src_m [N];
  logic [23:0] dst_q [$];
  logic [23:0] exp_pix = 24'h0;
  logic        exp_err_addr = 1'b0;
  logic        exp_err_ovf  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_pval"}, pixel_val, 1'b0);
    check_val({tag, "_pin"}, pixel_in, 24'h0);
    check_val({tag, "_dval"}, drain_val, 1'b0);
    check_val({tag, "_ddata"}, drain_data, 24'h0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_fdone"}, frame_done, 1'b0);
    check_val({tag, "_eaddr"}, err_addr, 1'b0);
    check_val({tag, "_eovf"}, err_ovf, 1'b0);
  endtask

  task automatic clear_inputs();
    start = 1'b0; load_val = 1'b0; load_data = 24'h0; rd_pixel = 1'b0;
    addr_pixel = '0; wr_pixel = 1'b0; pixel_out = 24'h0; proc_done = 1'b0; drain_rdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    check_idle("rst");
    reset = 1'b0;
    exp_pix = 24'h0; exp_err_addr = 1'b0; exp_err_ovf = 1'b0;
    dst_q.delete();
    step();
  endtask

  task automatic load_frame(input bit spec);
    start = 1'b1;
    step();
    start = 1'b0;
    exp_err_addr = 1'b0; exp_err_ovf = 1'b0;
    check_val("load_busy", busy, 1'b1);
    check_val("start_eaddr", err_addr, exp_err_addr);
    check_val("start_eovf", err_ovf, exp_err_ovf);
    for (int k = 0; k < N; k++) begin
      while ($urandom_range(0, 7) == 0) begin
        load_val = 1'b0; rd_pixel = 1'b1; addr_pixel = '0;
        step();
        check_val("load_rd_ignored", pixel_val, 1'b0);
        check_val("load_pin_hold", pixel_in, exp_pix);
      end
      rd_pixel  = 1'b0;
      load_val  = 1'b1;
      load_data = spec ? {k[7:0], ~k[7:0], 8'h5A} : 24'($urandom);
      src_m[k]  = load_data;
      step();
    end
    load_val = 1'b0;
  endtask

  task automatic spec_reads();
    logic [ADDR_W-1:0] addrs [4];
    logic [23:0]       exps  [4];
    addrs = '{12'd0, 12'd1, 12'd2499, 12'd3000};
    exps  = '{24'h00FF5A, 24'h01FE5A, 24'hC33C5A, 24'h000000};
    for (int i = 0; i < 4; i++) begin
      rd_pixel = 1'b1; addr_pixel = addrs[i];
      if (i == 3) exp_err_addr = 1'b1;
      step();
      check_val("spec_rd_val", pixel_val, 1'b1);
      check_val("spec_rd_data", pixel_in, exps[i]);
      check_val("spec_eaddr", err_addr, exp_err_addr);
    end
    rd_pixel = 1'b0;
    exp_pix = 24'h0;
    step();
    check_val("spec_rd_idle", pixel_val, 1'b0);
    check_val("spec_rd_hold", pixel_in, exp_pix);
  endtask

  task automatic serve(input int nwr, input bit pdone, input bit seq, input int abort);
    int written = 0;
    int cyc = 0;
    bit ex = 1'b0;
    bit rd, wr;
    logic [ADDR_W-1:0] a;
    check_val("serve_busy", busy, 1'b1);
    while (!ex) begin
      if (abort > 0 && cyc == abort) begin
        clear_inputs();
        return;
      end
      if (cyc >= 20000) begin
        check_val("serve_timeout", ex, 1'b1);
        clear_inputs();
        return;
      end
      rd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(N, 4095)) : 12'($urandom_range(0, N - 1));
      wr = (written < nwr) && ($urandom_range(0, 3) != 0);
      rd_pixel = rd; addr_pixel = a; wr_pixel = wr;
      pixel_out = seq ? 24'(written) : 24'($urandom);
      if (wr) begin
        dst_q.push_back(pixel_out);
        written++;
      end
      proc_done = pdone && (written == nwr);
      ex = (written == N) || proc_done;
      if (rd) begin
        exp_pix = (a < N) ? src_m[a] : 24'h0;
        if (a >= N) exp_err_addr = 1'b1;
      end
      step();
      check_val("rd_val", pixel_val, rd);
      check_val("rd_data", pixel_in, exp_pix);
      check_val("err_addr", err_addr, exp_err_addr);
      cyc++;
    end
    clear_inputs();
  endtask

  task automatic drain(input bit full, input bit poke, input int abort);
    int cyc = 0;
    int d = dst_q.size();
    bit seen = 1'b0;
    bit stalled = 1'b0;
    bit rdy;
    logic [23:0] held = 24'h0;
    if (d == 0) begin
      check_val("empty_fdone", frame_done, 1'b1);
      check_val("empty_busy", busy, 1'b0);
      check_val("empty_dval", drain_val, 1'b0);
      step();
      check_val("empty_fdone_once", frame_done, 1'b0);
      check_val("empty_dval2", drain_val, 1'b0);
      return;
    end
    while (dst_q.size() > 0) begin
      if (abort > 0 && cyc == abort) begin
        clear_inputs();
        return;
      end
      if (cyc >= 8 * d + 20) begin
        check_val("drain_timeout", dst_q.size(), 0);
        dst_q.delete();
        clear_inputs();
        return;
      end
      if (drain_val) seen = 1'b1;
      if (cyc == 2) check_val("drain_first", seen, 1'b1);
      if (stalled) begin
        check_val("stall_val", drain_val, 1'b1);
        check_val("stall_data", drain_data, held);
      end
      check_val("fdone_early", frame_done, 1'b0);
      if (poke && cyc == 1) check_val("err_ovf", err_ovf, exp_err_ovf);
      wr_pixel  = poke && (cyc == 0);
      pixel_out = 24'hABCDEF;
      if (poke && cyc == 0 && d == N) exp_err_ovf = 1'b1;
      rdy = full ? 1'b1 : 1'($urandom_range(0, 1));
      drain_rdy = rdy;
      stalled = drain_val && !rdy;
      held = drain_data;
      if (drain_val && rdy) begin
        check_val("drain_data", drain_data, dst_q[0]);
        void'(dst_q.pop_front());
      end
      step();
      cyc++;
    end
    clear_inputs();
    check_val("done_fdone", frame_done, 1'b1);
    check_val("done_busy", busy, 1'b0);
    check_val("done_dval", drain_val, 1'b0);
    check_val("done_eovf", err_ovf, exp_err_ovf);
    if (full) check_val("drain_rate", (cyc <= d + 2), 1'b1);
    step();
    check_val("fdone_once", frame_done, 1'b0);
    check_val("post_dval", drain_val, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();

    load_frame(1'b1);
    spec_reads();
    serve(N, 1'b0, 1'b1, 0);
    drain(1'b1, 1'b1, 0);

    load_frame(1'b0);
    serve(10, 1'b1, 1'b0, 0);
    drain(1'b0, 1'b0, 0);

    load_frame(1'b0);
    serve(0, 1'b1, 1'b0, 0);
    drain(1'b0, 1'b0, 0);

    load_frame(1'b0);
    serve(N, 1'b0, 1'b0, 0);
    drain(1'b0, 1'b0, 0);

    load_frame(1'b0);
    serve(N, 1'b0, 1'b0, 40);
    do_reset();

    load_frame(1'b0);
    serve(N, 1'b0, 1'b0, 0);
    drain(1'b0, 1'b0, 300);
    do_reset();

    load_frame(1'b0);
    serve(25, 1'b1, 1'b0, 0);
    drain(1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
